// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder around one full-adder cell, LSB first.
//            Optional subtract mode when SERIAL_ADDER_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_fa (
  output logic ripout,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic ripin
);
  assign c      = a ^ b ^ ripin;
  assign ripout = (a & b) | (ripin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  serial_adder_fa u_fa (
    .ripout (w_fa_carry),
    .c      (w_fa_sum),
    .a      (r_a_sr[0]),
    .b      (r_b_sr[0]),
    .ripin  (r_carry)
  );

  // Each new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_fa_sum;
    end else begin : g_res_wn
      assign w_res_next = {w_fa_sum, r_res_sr[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: a + ~b + 1; cin is ignored in this mode.
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= w_b_load;
            r_carry  <= w_c_load;
            r_res_sr <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_SHIFT;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_next;
          r_carry  <= w_fa_carry;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            sum     <= w_res_next;
            cout    <= w_fa_carry;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8); subtract cases need SERIAL_ADDER_SUB_EN.
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation for one edge (E0), then drops start.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv);
    a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until done is seen; n = -1 on timeout. busy_ok clears if busy drops early.
  task automatic wait_done(output int n, output bit busy_ok);
    n = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n; bit bok;
    launch(8'h05, 8'h03, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_after_e0: got busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(n, bok);
    checks++;
    if (n !== 8 || !bok) begin
      failures++;
      $display("FAIL basic_latency: got %0d edges busy_ok=%0d, want 8 edges busy_ok=1", n, bok);
    end
    checks++;
    if (sum !== 8'h08 || cout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got sum=%h cout=%b busy=%b, want 08 0 0", sum, cout, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || sum !== 8'h08) begin
      failures++;
      $display("FAIL basic_done_pulse: got done=%b sum=%h, want 0 08", done, sum);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit bok;
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(n, bok);
    checks++;
    if (n !== 8 || sum !== 8'h00 || cout !== 1'b1) begin
      failures++;
      $display("FAIL carry_out: got n=%0d sum=%h cout=%b, want 8 00 1", n, sum, cout);
    end
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b done=%b sum=%h, want 1 0 00", busy, done, sum);
    end
    wait_done(n, bok);
    checks++;
    if (n !== 8 || sum !== 8'h30 || cout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_result: got n=%0d sum=%h cout=%b, want 8 30 0", n, sum, cout);
    end
    tick();
  endtask

  task automatic test_cin();
    int n; bit bok;
    launch(8'h00, 8'h00, 1'b1, 1'b0);
    wait_done(n, bok);
    checks++;
    if (n !== 8 || sum !== 8'h01 || cout !== 1'b0) begin
      failures++;
      $display("FAIL cin_zero: got n=%0d sum=%h cout=%b, want 8 01 0", n, sum, cout);
    end
    tick();
    launch(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done(n, bok);
    checks++;
    if (n !== 8 || sum !== 8'hFF || cout !== 1'b1) begin
      failures++;
      $display("FAIL cin_max: got n=%0d sum=%h cout=%b, want 8 ff 1", n, sum, cout);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int n; bit bok; int extra;
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    tick(); tick();
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bok);
    checks++;
    if (n !== 5 || !bok || sum !== 8'h46 || cout !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore: got n=%0d busy_ok=%0d sum=%h cout=%b, want 5 1 46 0", n, bok, sum, cout);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL busy_no_second_op: got %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    int n; bit bok; int extra;
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      failures++;
      $display("FAIL midreset_clear: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL midreset_no_done: got %0d active cycles, want 0", extra);
    end
    launch(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(n, bok);
    checks++;
    if (n !== 8 || sum !== 8'h80 || cout !== 1'b0) begin
      failures++;
      $display("FAIL midreset_fresh_op: got n=%0d sum=%h cout=%b, want 8 80 0", n, sum, cout);
    end
    tick();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int n; bit bok;
    launch(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done(n, bok);
    checks++;
    if (n !== 8 || sum !== 8'hFE || cout !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow: got n=%0d sum=%h cout=%b, want 8 fe 0", n, sum, cout);
    end
    tick();
    launch(8'h09, 8'h04, 1'b1, 1'b1);
    wait_done(n, bok);
    checks++;
    if (n !== 8 || sum !== 8'h05 || cout !== 1'b1) begin
      failures++;
      $display("FAIL sub_no_borrow: got n=%0d sum=%h cout=%b, want 8 05 1", n, sum, cout);
    end
    tick();
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_cin();
    test_start_while_busy();
    test_reset_mid_op();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
